// File: rtl/rot8_pkg.sv
// rot8_pkg: shared definitions for the rot8_arbiter slice.
//   DATA_W / AMT_W / NUM_REQ : fixed datapath widths and requester count
//   state_e                  : result-slot state (EMPTY / FULL)
//   left_amt()               : maps a (direction, amount) pair onto the
//                              equivalent rotate-left amount
package rot8_pkg;

  localparam int DATA_W  = 8;
  localparam int AMT_W   = 3;
  localparam int NUM_REQ = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Right by n equals left by (8 - n) mod 8; the subtraction wraps in AMT_W
  // bits, so right-by-0 stays 0 (passthrough).
  function automatic logic [AMT_W-1:0] left_amt(input logic right,
                                                input logic [AMT_W-1:0] amt);
    return right ? ({AMT_W{1'b0}} - amt) : amt;
  endfunction

endpackage

// File: rtl/rot8_core.sv
// rot8_core: purely combinational 8-bit rotate-left.
//   a   : operand
//   amt : rotate-left amount (0..7); bit j of y = a[(j - amt) mod 8]
//   y   : rotated byte
module rot8_core
  import rot8_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] y
);

  // The right shift by 8 at amt=0 yields zero, so amt=0 passes a through.
  always_comb begin
    y = (a << amt) | (a >> (4'd8 - {1'b0, amt}));
  end

endmodule

// File: rtl/rot8_arbiter.sv
// rot8_arbiter: two requesters share one rotate datapath under round-robin
// arbitration; one registered, ID-tagged result on a valid/ready port.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid[1:0]        : per-requester request valid
//   req_ready[1:0]        : per-requester accept (one-hot or zero)
//   req_data[15:0]        : operands, requester i at [8i+7:8i]
//   req_amt[5:0]          : amounts, requester i at [3i+2:3i]
//   req_dir[1:0]          : 0 = left, 1 = right (only with ROT8_RIGHT_EN)
//   res_valid/res_ready   : result handshake
//   res_data[7:0], res_id : rotated byte and the requester that produced it
//
// Handshake: a transfer happens on any edge where valid & ready are both
// high; a producer must hold its payload stable while valid and not ready,
// and ready never depends on anything but state, res_ready, the valids and
// the round-robin pointer.
//
// Build option: define ROT8_RIGHT_EN to honour req_dir; otherwise every
// request rotates left and req_dir is ignored.
module rot8_arbiter
  import rot8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_data,
  input  logic [5:0]  req_amt,
  input  logic [1:0]  req_dir,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_id
);

`ifdef ROT8_RIGHT_EN
  localparam logic RIGHT_EN = 1'b1;
`else
  localparam logic RIGHT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_id_q, res_id_d;

  logic              slot_free;
  logic              gnt_any;
  logic              gnt_id;
  logic [DATA_W-1:0] sel_data;
  logic [AMT_W-1:0]  sel_amt;
  logic              sel_dir;
  logic [AMT_W-1:0]  eff_amt;
  logic [DATA_W-1:0] rot_y;

  // Arbitration: the slot is free when empty or being drained this cycle.
  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    slot_free = (state_q == EMPTY) || res_ready;
    gnt_any   = 1'b0;
    gnt_id    = 1'b0;
    if (slot_free) begin
      if (&req_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_grant_q;
      end else if (req_valid[0]) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (req_valid[1]) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  // rst_n gating keeps ready low for the whole reset assertion window.
  assign req_ready = {rst_n & gnt_any & gnt_id, rst_n & gnt_any & ~gnt_id};

  // Single shared datapath fed from the granted requester.
  always_comb begin
    sel_data = gnt_id ? req_data[15:8] : req_data[7:0];
    sel_amt  = gnt_id ? req_amt[5:3]   : req_amt[2:0];
    sel_dir  = gnt_id ? req_dir[1]     : req_dir[0];
    eff_amt  = left_amt(RIGHT_EN & sel_dir, sel_amt);
  end

  rot8_core u_core (
    .a   (sel_data),
    .amt (eff_amt),
    .y   (rot_y)
  );

  // Next state: a grant always loads (covers drain+accept with no bubble);
  // otherwise a drain empties the slot and a stall holds everything.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    if (gnt_any) begin
      state_d      = FULL;
      last_grant_d = gnt_id;
      res_data_d   = rot_y;
      res_id_d     = gnt_id;
    end else if ((state_q == FULL) && res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_rot8_arbiter.sv
// tb_rot8_arbiter: directed bench for rot8_arbiter.
module tb_rot8_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_data;
  logic [5:0]  req_amt;
  logic [1:0]  req_dir;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        res_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries are {id, data}.
  logic [8:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rot8_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_dir   (req_dir),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_rot(input logic [7:0] a,
                                           input logic [2:0] amt,
                                           input logic dir);
    logic [7:0] y;
    logic [2:0] k;
    logic [2:0] idx;
`ifdef ROT8_RIGHT_EN
    k = dir ? (3'd0 - amt) : amt;
`else
    k = amt;
    if (dir) k = amt;
`endif
    for (int j = 0; j < 8; j++) begin
      idx  = 3'(j) - k;
      y[j] = a[idx];
    end
    return y;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic v, input logic [7:0] d,
                           input logic [2:0] a, input logic dr);
    req_valid[i]         = v;
    req_data[8*i +: 8]   = d;
    req_amt[3*i +: 3]    = a;
    req_dir[i]           = dr;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_q"}, 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 16'(res_valid), 16'd1);
      check({tag, "_data"},  16'(res_data),  16'(e[7:0]));
      check({tag, "_id"},    16'(res_id),    16'(e[8]));
    end
  endtask

  logic [7:0] exp_right;

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_data  = '0;
    req_amt   = '0;
    req_dir   = '0;
    res_ready = 1'b0;

    // Reset values, ready suppressed even with valid requests.
    #3;
    req_valid = 2'b11;
    #1;
    check("rst_res_valid", 16'(res_valid), 16'd0);
    check("rst_res_data",  16'(res_data),  16'h00);
    check("rst_res_id",    16'(res_id),    16'd0);
    check("rst_req_ready", 16'(req_ready), 16'b00);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single request from requester 0: B4 rotl 3 = A5.
    drive_req(0, 1'b1, 8'hB4, 3'd3, 1'b0);
    #1;
    check("t1_ready", 16'(req_ready), 16'b01);
    exp_q.push_back({1'b0, 8'hA5});
    step();
    drive_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    check_result("t1");
    res_ready = 1'b1;
    step();
    check("t1_drain_valid", 16'(res_valid), 16'd0);

    // Fresh arbitration, both valid every cycle: grants 0,1,0,1.
    apply_reset();
    res_ready = 1'b1;
    drive_req(0, 1'b1, 8'h01, 3'd1, 1'b0);
    drive_req(1, 1'b1, 8'h80, 3'd1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 16'(req_ready), (k % 2 == 0) ? 16'b01 : 16'b10);
      if (k % 2 == 0) exp_q.push_back({1'b0, 8'h02});
      else            exp_q.push_back({1'b1, 8'h01});
      step();
      check_result("rr");
    end
    drive_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    drive_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
    step();
    check("rr_drain_valid", 16'(res_valid), 16'd0);

    // Stall: hold 3C for 5 cycles while requester 1 waits.
    res_ready = 1'b0;
    drive_req(0, 1'b1, 8'h3C, 3'd0, 1'b0);
    exp_q.push_back({1'b0, 8'h3C});
    step();
    drive_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    check_result("stall_load");
    drive_req(1, 1'b1, 8'h01, 3'd1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_ready", 16'(req_ready), 16'b00);
      check("stall_data",  16'(res_data),  16'h3C);
      check("stall_id",    16'(res_id),    16'd0);
      check("stall_valid", 16'(res_valid), 16'd1);
      step();
    end
    // Drain and accept in the same cycle; also exercises the direction bit.
    res_ready = 1'b1;
    #1;
    check("drain_accept_ready", 16'(req_ready), 16'b10);
`ifdef ROT8_RIGHT_EN
    exp_right = 8'h80;
`else
    exp_right = 8'h02;
`endif
    exp_q.push_back({1'b1, exp_right});
    step();
    drive_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
    check_result("dir");
    check("dir_model", 16'(exp_right), 16'(model_rot(8'h01, 3'd1, 1'b1)));
    step();
    check("dir_drain_valid", 16'(res_valid), 16'd0);

    // Amount sweep on 96, back to back.
    for (int a = 0; a < 8; a++) begin
      drive_req(0, 1'b1, 8'h96, 3'(a), 1'b0);
      exp_q.push_back({1'b0, model_rot(8'h96, 3'(a), 1'b0)});
      step();
      check_result("sweep");
      if (a == 0) check("sweep_amt0", 16'(res_data), 16'h96);
      if (a == 7) check("sweep_amt7", 16'(res_data), 16'h4B);
    end
    drive_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    step();

    // Reset while FULL: result dropped asynchronously, requester 0 first.
    // Requester 0 won last, so a tie here would otherwise favour requester 1.
    res_ready = 1'b0;
    drive_req(0, 1'b1, 8'h55, 3'd2, 1'b0);
    step();
    drive_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    check("pre_rst_valid", 16'(res_valid), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 16'(res_valid), 16'd0);
    check("async_rst_data",  16'(res_data),  16'h00);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    drive_req(0, 1'b1, 8'h0F, 3'd4, 1'b0);
    drive_req(1, 1'b1, 8'hC3, 3'd2, 1'b0);
    #1;
    check("post_rst_ready0", 16'(req_ready), 16'b01);
    exp_q.push_back({1'b0, 8'hF0});
    step();
    check_result("post_rst0");
    check("post_rst_ready1", 16'(req_ready), 16'b10);
    exp_q.push_back({1'b1, 8'h0F});
    step();
    check_result("post_rst1");
    drive_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
    drive_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
    step();

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
